// File: rtl/npu_io_pkg.sv
// Shared NPU byte-interface definitions.
// Holds the destination select encodings used by both the input router and
// the output byte mux, plus the target-assembler FSM state type.
package npu_io_pkg;

    localparam logic [2:0] SEL_FIFO    = 3'b000;
    localparam logic [2:0] SEL_TGT_LSB = 3'b001;
    localparam logic [2:0] SEL_TGT_MSB = 3'b010;
    localparam logic [2:0] SEL_DEB     = 3'b011;
    localparam logic [2:0] SEL_GND     = 3'b100;

    typedef enum logic {
        T_IDLE,
        T_LSB_HELD
    } tgt_state_t;

endpackage

// File: rtl/sipo_deb.sv
// Debug serial-in/parallel-out capture register.
// Shifts one byte per shift_en; after DBG_BYTES bytes the completed word is
// copied to data (first byte in the top byte) and valid pulses for one cycle.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   shift_en    accept din this cycle
//   din         byte to shift in
//   data        last completed word, held between captures
//   valid       one-cycle pulse when data updates
module sipo_deb #(
    parameter int unsigned DBG_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   shift_en,
    input  logic [7:0]             din,
    output logic [8*DBG_BYTES-1:0] data,
    output logic                   valid
);

    localparam int unsigned CW = (DBG_BYTES > 1) ? $clog2(DBG_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DBG_BYTES - 1);

    logic [8*DBG_BYTES-1:0] shreg_q, shreg_d;
    logic [8*DBG_BYTES-1:0] data_q, data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   valid_q, valid_d;

    always_comb begin
        shreg_d = shreg_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (shift_en) begin
            shreg_d = {shreg_q[8*DBG_BYTES-9:0], din};
            if (cnt_q == LAST) begin
                // Word complete: capture and start a fresh word next byte.
                data_d  = shreg_d;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/din_router.sv
// Input byte router for the NPU byte interface.
// Accepts bytes from D_IN under DIN_VALID/DIN_READY and routes each by SEL_IN
// to the input FIFO (combinational), the two-byte target assembler, or the
// debug SIPO capture. Reserved selects and orphan MSBs raise sticky errors.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   SEL_IN, D_IN             destination select and byte
//   DIN_VALID, DIN_READY     input handshake
//   fifo_wdata, fifo_wr      FIFO write port; fifo_full back-pressure
//   target, target_valid     assembled {msb, lsb} and its update pulse
//   sipo_data, sipo_valid    debug word and its update pulse
//   err_seq, err_sel         sticky errors, cleared by ERR_CLR
module din_router
    import npu_io_pkg::*;
#(
    parameter int unsigned DBG_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             SEL_IN,
    input  logic [7:0]             D_IN,
    input  logic                   DIN_VALID,
    output logic                   DIN_READY,
    output logic [7:0]             fifo_wdata,
    output logic                   fifo_wr,
    input  logic                   fifo_full,
    output logic [15:0]            target,
    output logic                   target_valid,
    output logic [8*DBG_BYTES-1:0] sipo_data,
    output logic                   sipo_valid,
    output logic                   err_seq,
    output logic                   err_sel,
    input  logic                   ERR_CLR
);

    tgt_state_t  state_q, state_d;
    logic [7:0]  lsb_hold_q, lsb_hold_d;
    logic [15:0] target_q, target_d;
    logic        target_valid_q, target_valid_d;
    logic        err_seq_q, err_seq_d;
    logic        err_sel_q, err_sel_d;
    logic        accept;

    // Ready depends only on the select and FIFO state, never on DIN_VALID.
    assign DIN_READY  = !((SEL_IN == SEL_FIFO) && fifo_full);
    assign accept     = DIN_VALID && DIN_READY;
    assign fifo_wr    = accept && (SEL_IN == SEL_FIFO);
    assign fifo_wdata = D_IN;

    always_comb begin
        state_d        = state_q;
        lsb_hold_d     = lsb_hold_q;
        target_d       = target_q;
        target_valid_d = 1'b0;
        // Clear first so a same-cycle set below takes priority.
        err_seq_d      = err_seq_q && !ERR_CLR;
        err_sel_d      = err_sel_q && !ERR_CLR;
        if (accept) begin
            case (SEL_IN)
                SEL_TGT_LSB: begin
                    lsb_hold_d = D_IN;
                    state_d    = T_LSB_HELD;
                end
                SEL_TGT_MSB: begin
                    if (state_q == T_LSB_HELD) begin
                        target_d       = {D_IN, lsb_hold_q};
                        target_valid_d = 1'b1;
                        state_d        = T_IDLE;
                    end else begin
                        err_seq_d = 1'b1;
                    end
                end
                SEL_FIFO, SEL_DEB, SEL_GND: ;
                default: err_sel_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= T_IDLE;
            lsb_hold_q     <= '0;
            target_q       <= '0;
            target_valid_q <= 1'b0;
            err_seq_q      <= 1'b0;
            err_sel_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lsb_hold_q     <= lsb_hold_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
            err_seq_q      <= err_seq_d;
            err_sel_q      <= err_sel_d;
        end
    end

    assign target       = target_q;
    assign target_valid = target_valid_q;
    assign err_seq      = err_seq_q;
    assign err_sel      = err_sel_q;

    sipo_deb #(
        .DBG_BYTES (DBG_BYTES)
    ) u_sipo_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept && (SEL_IN == SEL_DEB)),
        .din      (D_IN),
        .data     (sipo_data),
        .valid    (sipo_valid)
    );

endmodule

// File: tb/tb_din_router.sv
// Self-checking bench for din_router: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_din_router;

    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    SEL_IN;
    logic [7:0]    D_IN;
    logic          DIN_VALID;
    logic          DIN_READY;
    logic [7:0]    fifo_wdata;
    logic          fifo_wr;
    logic          fifo_full;
    logic [15:0]   target;
    logic          target_valid;
    logic [8*NB-1:0] sipo_data;
    logic          sipo_valid;
    logic          err_seq;
    logic          err_sel;
    logic          ERR_CLR;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state.
    bit          m_pending;
    logic [7:0]  m_lsb;
    logic [15:0] m_target;
    bit          m_tv;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_sipo;
    bit          m_sv;
    bit          m_err_seq;
    bit          m_err_sel;

    always #5 clk = ~clk;

    din_router #(
        .DBG_BYTES (NB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SEL_IN       (SEL_IN),
        .D_IN         (D_IN),
        .DIN_VALID    (DIN_VALID),
        .DIN_READY    (DIN_READY),
        .fifo_wdata   (fifo_wdata),
        .fifo_wr      (fifo_wr),
        .fifo_full    (fifo_full),
        .target       (target),
        .target_valid (target_valid),
        .sipo_data    (sipo_data),
        .sipo_valid   (sipo_valid),
        .err_seq      (err_seq),
        .err_sel      (err_sel),
        .ERR_CLR      (ERR_CLR)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0;
        m_lsb     = 8'h00;
        m_target  = 16'h0000;
        m_tv      = 0;
        m_bytes.delete();
        m_sipo    = 32'h0;
        m_sv      = 0;
        m_err_seq = 0;
        m_err_sel = 0;
    endtask

    task automatic check_regs();
        check_val("target", 64'(target), 64'(m_target));
        check_val("target_valid", 64'(target_valid), 64'(m_tv));
        check_val("sipo_data", 64'(sipo_data), 64'(m_sipo));
        check_val("sipo_valid", 64'(sipo_valid), 64'(m_sv));
        check_val("err_seq", 64'(err_seq), 64'(m_err_seq));
        check_val("err_sel", 64'(err_sel), 64'(m_err_sel));
    endtask

    // Called just after a rising edge; applies one cycle of stimulus.
    task automatic step(input logic [2:0] sel, input logic [7:0] d, input bit v,
                        input bit ff, input bit clr);
        bit exp_rdy;
        bit acc;
        logic [31:0] w;
        SEL_IN = sel; D_IN = d; DIN_VALID = v; fifo_full = ff; ERR_CLR = clr;
        #1;
        exp_rdy = !(sel == 3'd0 && ff);
        acc     = v && exp_rdy;
        check_val("DIN_READY", 64'(DIN_READY), 64'(exp_rdy));
        check_val("fifo_wr", 64'(fifo_wr), 64'(acc && sel == 3'd0));
        check_val("fifo_wdata", 64'(fifo_wdata), 64'(d));
        m_tv = 0;
        m_sv = 0;
        if (clr) begin
            m_err_seq = 0;
            m_err_sel = 0;
        end
        if (acc) begin
            if (sel == 3'd1) begin
                m_lsb = d;
                m_pending = 1;
            end else if (sel == 3'd2) begin
                if (m_pending) begin
                    m_target  = {d, m_lsb};
                    m_tv      = 1;
                    m_pending = 0;
                end else begin
                    m_err_seq = 1;
                end
            end else if (sel == 3'd3) begin
                m_bytes.push_back(d);
                if (m_bytes.size() == NB) begin
                    w = 32'h0;
                    foreach (m_bytes[i]) w = (w << 8) | 32'(m_bytes[i]);
                    m_sipo = w;
                    m_sv   = 1;
                    m_bytes.delete();
                end
            end else if (sel >= 3'd5) begin
                m_err_sel = 1;
            end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    // Called just after a rising edge; asynchronous reset pulse mid-cycle.
    task automatic do_reset();
        DIN_VALID = 0; ERR_CLR = 0; fifo_full = 0; SEL_IN = 3'd0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_regs();
        check_val("fifo_wr_rst", 64'(fifo_wr), 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; SEL_IN = 3'd0; D_IN = 8'h00; DIN_VALID = 0; fifo_full = 0; ERR_CLR = 0;
        model_reset();
        #3;
        check_regs();
        check_val("ready_rst", 64'(DIN_READY), 64'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        step(3'd0, 8'h00, 0, 0, 0);

        // Target pair 16'h1234.
        step(3'd1, 8'h34, 1, 0, 0);
        step(3'd2, 8'h12, 1, 0, 0);
        check_val("tgt_1234", 64'(target), 64'h1234);
        check_val("tv_pulse", 64'(target_valid), 64'd1);
        step(3'd0, 8'h00, 0, 0, 0);
        check_val("tv_one_cycle", 64'(target_valid), 64'd0);

        // Orphan MSB, then clear racing a new orphan.
        step(3'd2, 8'hAB, 1, 0, 0);
        check_val("err_seq_set", 64'(err_seq), 64'd1);
        check_val("tgt_kept", 64'(target), 64'h1234);
        step(3'd2, 8'hAC, 1, 0, 1);
        check_val("set_wins", 64'(err_seq), 64'd1);
        step(3'd4, 8'h00, 0, 0, 1);

        // FIFO back-pressure with held byte.
        step(3'd0, 8'h5A, 1, 1, 0);
        step(3'd0, 8'h5A, 1, 1, 0);
        step(3'd0, 8'h5A, 1, 0, 0);
        step(3'd0, 8'h5A, 0, 0, 0);

        // SIPO DEADBEEF plus a 5th byte, with an LSB interleaved.
        step(3'd3, 8'hDE, 1, 0, 0);
        step(3'd1, 8'h77, 1, 0, 0);
        step(3'd3, 8'hAD, 1, 0, 0);
        step(3'd3, 8'hBE, 1, 0, 0);
        step(3'd3, 8'hEF, 1, 0, 0);
        check_val("sipo_word", 64'(sipo_data), 64'hDEADBEEF);
        step(3'd3, 8'h99, 1, 0, 0);
        check_val("sipo_no5th", 64'(sipo_valid), 64'd0);
        step(3'd2, 8'h88, 1, 0, 0);
        check_val("tgt_interleave", 64'(target), 64'h8877);
        step(3'd6, 8'h00, 1, 0, 0);

        // LSB lost on reset.
        step(3'd1, 8'h55, 1, 0, 0);
        step(3'd3, 8'h01, 1, 0, 0);
        do_reset();
        step(3'd2, 8'h66, 1, 0, 0);
        check_val("lsb_lost_err", 64'(err_seq), 64'd1);
        check_val("lsb_lost_tgt", 64'(target), 64'h0000);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] s;
            s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            step(s, 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0));
            if (i % 700 == 699) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/din_router.md
# din_router

Input-side counterpart of the NPU byte output multiplexer. It accepts bytes from the shared 8-bit D_IN bus under a valid/ready handshake and routes each byte by SEL_IN. Destinations are the input FIFO write port, a two-byte target register assembler, and a debug serial-in/parallel-out capture register. It sits between the external byte interface and the NPU core, and uses the same destination encoding as D_OUT selection.

## Interface
- DBG_BYTES, default 4: number of bytes per debug SIPO word (≥2).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- SEL_IN  in  3  destination select, sampled with each accepted byte.
- D_IN  in  8  input byte.
- DIN_VALID  in  1  byte present on D_IN.
- DIN_READY  out  1  block can accept byte this cycle.
- fifo_wdata  out  8  byte to input FIFO.
- fifo_wr  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO cannot take a write this cycle.
- target  out  16  assembled target value, {msb, lsb}.
- target_valid  out  1  one-cycle pulse: target updated.
- sipo_data  out  8*DBG_BYTES  captured debug word, first byte received in the top byte.
- sipo_valid  out  1  one-cycle pulse: sipo_data updated.
- err_seq  out  1  sticky: MSB received with no pending LSB.
- err_sel  out  1  sticky: reserved SEL_IN code received.
- ERR_CLR  in  1  clears both sticky errors.

## Operation
- Accept = DIN_VALID & DIN_READY. Nothing changes state without an accept.
- DIN_READY = !(SEL_IN==3'b000 & fifo_full). It is combinational from SEL_IN and fifo_full only, never from DIN_VALID.
- SEL_IN 000 (FIFO):
  - fifo_wr = accept & SEL_IN==000 (combinational).
  - fifo_wdata = D_IN.
  - No byte is ever written while fifo_full=1.
- Target assembler FSM, states T_IDLE and T_LSB_HELD:
  - SEL 001 (LSB): store D_IN in lsb_hold and go to T_LSB_HELD. An LSB in T_LSB_HELD overwrites lsb_hold without error.
  - SEL 010 (MSB) in T_LSB_HELD: target <= {D_IN, lsb_hold}, target_valid pulses, go to T_IDLE.
  - SEL 010 in T_IDLE: byte is dropped, err_seq is set, target is unchanged.
- SIPO (SEL 011):
  - Each accepted byte shifts into the shift register: shreg <= {shreg[8*DBG_BYTES-9:0], D_IN}, and cnt increments.
  - On the byte with cnt==DBG_BYTES-1: sipo_data <= the completed word, sipo_valid pulses, cnt <= 0.
  - sipo_data holds its value between captures.
- SEL 100: byte accepted and discarded, with no error (grounded destination).
- SEL 101–111: byte accepted and discarded; err_sel is set.
- Error flags: ERR_CLR clears both. If a set and ERR_CLR occur in the same cycle, the set wins.
- Destinations are independent: a FIFO/SIPO/other byte arriving between an LSB and its MSB does not disturb the T_LSB_HELD state.

## Timing
- Reset values: DIN_READY follows its equation; fifo_wr=0; fifo_wdata=D_IN; target=16'h0000; target_valid=0; sipo_data=0; sipo_valid=0; err_seq=0; err_sel=0; FSM=T_IDLE; cnt=0; lsb_hold=0.
- FIFO path: zero latency, combinational within the accept cycle.
- Target, sipo_data, and error flags: registered. Visible the cycle after the accepting edge, with the valid pulse in that same cycle, exactly one cycle wide.
- Back-to-back accepts every cycle are supported on all paths. There are no bubbles.
- Reset asserted mid-operation: a pending LSB and a partial SIPO word are discarded. target and sipo_data return to 0.
- DBG_BYTES boundary: cnt wraps from DBG_BYTES-1 to 0 exactly on the capture byte, so the next byte starts a fresh word.

## Structure
- Shared package npu_io_pkg holds:
  - SEL encodings: SEL_FIFO=3'b000, SEL_TGT_LSB=3'b001, SEL_TGT_MSB=3'b010, SEL_DEB=3'b011, SEL_GND=3'b100. These are shared with the output mux.
  - The target FSM state typedef.
- Sub-module sipo_deb (parameter DBG_BYTES; inputs shift_en and din; outputs data and valid) is the natural split. It mirrors the debug PISO on the output side.
- Everything else stays in din_router.

## Test plan
- Reset, then idle: all outputs at reset values. With SEL_IN=000 and fifo_full=0, DIN_READY=1.
- SEL 001 with D_IN=8'h34, then SEL 010 with D_IN=8'h12:
  - target=16'h1234 one cycle after the MSB.
  - target_valid high for exactly 1 cycle.
  - err_seq=0.
- SEL 010 with D_IN=8'hAB from T_IDLE:
  - err_seq=1 and target unchanged.
  - Then ERR_CLR together with another orphan MSB: err_seq stays 1.
- SEL 000 with fifo_full=1 and DIN_VALID held: DIN_READY=0 and fifo_wr=0. Drop fifo_full: a single fifo_wr with fifo_wdata equal to the held byte.
- DBG_BYTES=4, SEL 011 with bytes 8'hDE, 8'hAD, 8'hBE, 8'hEF back-to-back:
  - sipo_data=32'hDEADBEEF.
  - sipo_valid pulses once.
  - A 5th byte does not pulse.
- SEL 001 with 8'h55, SEL 011 with 8'h01, reset pulse, then SEL 010 with 8'h66: err_seq=1 and target=16'h0000, because the LSB was lost on reset.
